// File: rtl/dbus_arbiter_if.sv
// rtl/dbus_arbiter_if.sv - CPU/DMA/bridge data-bus signal bundle for dbus_arbiter
interface dbus_arbiter_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_op;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_lock;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_op;
  logic        dma_gnt;
  logic [31:0] dma_rdata;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_op;
  logic [31:0] bus_rdata;
  logic        bus_owner;

  // Arbiter side: takes requests and bridge read data, drives grants and the bridge.
  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_op,
    input  dma_req, dma_lock, dma_addr, dma_wdata, dma_op,
    input  bus_rdata,
    output cpu_gnt, cpu_stall, cpu_rdata,
    output dma_gnt, dma_rdata,
    output bus_addr, bus_wdata, bus_op, bus_owner
  );

  // Requester/bridge side: the mirror image of the arbiter view.
  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_op,
    output dma_req, dma_lock, dma_addr, dma_wdata, dma_op,
    output bus_rdata,
    input  cpu_gnt, cpu_stall, cpu_rdata,
    input  dma_gnt, dma_rdata,
    input  bus_addr, bus_wdata, bus_op, bus_owner
  );
endinterface

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-master (CPU/DMA) data-bus arbiter with locked DMA bursts; optional DBUS_STARVE_GUARD_EN
module dbus_arbiter
`ifdef DBUS_STARVE_GUARD_EN
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
)
`endif
(
  input logic     clk,
  input logic     reset_n,
  dbus_arbiter_if.slave dbus
);

  typedef enum logic {FREE = 1'b0, DMA_LOCKED = 1'b1} state_t;

  state_t state;
  logic   last_grant;   // 0 = CPU, 1 = DMA; loser of the next FREE tie
  logic   owner_q;      // owner shown on bus_owner while the bus is idle
  logic   cpu_win;
  logic   dma_win;
`ifdef DBUS_STARVE_GUARD_EN
  logic [CNT_W-1:0] burst_cnt;
  logic             force_cpu;
`endif

  // Pick the winner for this cycle from the current state and the requests.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
`ifdef DBUS_STARVE_GUARD_EN
    force_cpu = 1'b0;
`endif
    if (state == FREE) begin
      cpu_win = dbus.cpu_req & (~dbus.dma_req | last_grant);
      dma_win = dbus.dma_req & (~dbus.cpu_req | ~last_grant);
    end else begin
`ifdef DBUS_STARVE_GUARD_EN
      // A full-length burst with the CPU waiting yields exactly one slot.
      force_cpu = (burst_cnt == CNT_W'(MAX_BURST)) & dbus.cpu_req;
      dma_win   = dbus.dma_req & ~force_cpu;
      cpu_win   = dbus.cpu_req & (~dbus.dma_req | force_cpu);
`else
      dma_win   = dbus.dma_req;
      cpu_win   = dbus.cpu_req & ~dbus.dma_req;
`endif
    end
  end

  // Grants and stall are forced low while reset is asserted.
  assign dbus.cpu_gnt   = cpu_win & reset_n;
  assign dbus.dma_gnt   = dma_win & reset_n;
  assign dbus.cpu_stall = dbus.cpu_req & ~dbus.cpu_gnt & reset_n;

  assign dbus.bus_addr  = dbus.cpu_gnt ? dbus.cpu_addr  : (dbus.dma_gnt ? dbus.dma_addr  : 32'h0);
  assign dbus.bus_wdata = dbus.cpu_gnt ? dbus.cpu_wdata : (dbus.dma_gnt ? dbus.dma_wdata : 32'h0);
  assign dbus.bus_op    = dbus.cpu_gnt ? dbus.cpu_op    : (dbus.dma_gnt ? dbus.dma_op    : 4'h0);
  assign dbus.cpu_rdata = dbus.cpu_gnt ? dbus.bus_rdata : 32'h0;
  assign dbus.dma_rdata = dbus.dma_gnt ? dbus.bus_rdata : 32'h0;
  assign dbus.bus_owner = dbus.dma_gnt ? 1'b1 : (dbus.cpu_gnt ? 1'b0 : owner_q);

  // Lock FSM, fairness history and burst counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FREE;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
`ifdef DBUS_STARVE_GUARD_EN
      burst_cnt  <= '0;
`endif
    end else begin
      if (dbus.cpu_gnt | dbus.dma_gnt) begin
        last_grant <= dbus.dma_gnt;
        owner_q    <= dbus.dma_gnt;
      end
      case (state)
        FREE: begin
          if (dbus.dma_gnt & dbus.dma_lock) begin
            state <= DMA_LOCKED;
`ifdef DBUS_STARVE_GUARD_EN
            burst_cnt <= CNT_W'(1);
`endif
          end
        end
        DMA_LOCKED: begin
          if (dbus.dma_gnt) begin
            if (!dbus.dma_lock) begin
              state <= FREE;
`ifdef DBUS_STARVE_GUARD_EN
              burst_cnt <= '0;
`endif
            end
`ifdef DBUS_STARVE_GUARD_EN
            else if (burst_cnt != CNT_W'(MAX_BURST)) begin
              burst_cnt <= burst_cnt + CNT_W'(1);
            end
          end else if (force_cpu) begin
            burst_cnt <= '0;
`endif
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - directed scoreboard bench for dbus_arbiter
module tb_dbus_arbiter;

  localparam logic [3:0] CPU_SW = 4'h6;
  localparam logic [3:0] CPU_LW = 4'h5;
  localparam logic [3:0] DMA_WR = 4'hA;
  localparam logic [3:0] DMA_RD = 4'h9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dbus_arbiter_if dbus ();

  dbus_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dbus    (dbus)
  );

  typedef struct {
    string       tag;
    logic        cg;
    logic        dg;
    logic        stall;
    logic        owner;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  op;
    logic [31:0] crd;
    logic [31:0] drd;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic exp_owner = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
  endtask

  task automatic drive(input logic cr, input logic [31:0] ca, input logic [3:0] cop,
                       input logic dr, input logic dl, input logic [31:0] da, input logic [3:0] dop);
    dbus.cpu_req   = cr;
    dbus.cpu_addr  = ca;
    dbus.cpu_wdata = ca ^ 32'h5A5A_5A5A;
    dbus.cpu_op    = cop;
    dbus.dma_req   = dr;
    dbus.dma_lock  = dl;
    dbus.dma_addr  = da;
    dbus.dma_wdata = da ^ 32'hA5A5_0F0F;
    dbus.dma_op    = dop;
    dbus.bus_rdata = $urandom;
  endtask

  // Expected outputs for the inputs currently being driven, given the expected grants.
  task automatic push_exp(input string tag, input logic egc, input logic egd);
    exp_t e;
    e.tag   = tag;
    e.cg    = egc;
    e.dg    = egd;
    e.stall = dbus.cpu_req & ~egc & reset_n;
    e.owner = egd ? 1'b1 : (egc ? 1'b0 : exp_owner);
    e.addr  = egc ? dbus.cpu_addr  : (egd ? dbus.dma_addr  : 32'h0);
    e.wdata = egc ? dbus.cpu_wdata : (egd ? dbus.dma_wdata : 32'h0);
    e.op    = egc ? dbus.cpu_op    : (egd ? dbus.dma_op    : 4'h0);
    e.crd   = egc ? dbus.bus_rdata : 32'h0;
    e.drd   = egd ? dbus.bus_rdata : 32'h0;
    exp_owner = e.owner;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".cpu_gnt"},   {31'b0, dbus.cpu_gnt},   {31'b0, e.cg});
    chk({e.tag, ".dma_gnt"},   {31'b0, dbus.dma_gnt},   {31'b0, e.dg});
    chk({e.tag, ".cpu_stall"}, {31'b0, dbus.cpu_stall}, {31'b0, e.stall});
    chk({e.tag, ".bus_owner"}, {31'b0, dbus.bus_owner}, {31'b0, e.owner});
    chk({e.tag, ".bus_addr"},  dbus.bus_addr,           e.addr);
    chk({e.tag, ".bus_wdata"}, dbus.bus_wdata,          e.wdata);
    chk({e.tag, ".bus_op"},    {28'b0, dbus.bus_op},    {28'b0, e.op});
    chk({e.tag, ".cpu_rdata"}, dbus.cpu_rdata,          e.crd);
    chk({e.tag, ".dma_rdata"}, dbus.dma_rdata,          e.drd);
  endtask

  task automatic step(input string tag,
                      input logic cr, input logic [31:0] ca, input logic [3:0] cop,
                      input logic dr, input logic dl, input logic [31:0] da, input logic [3:0] dop,
                      input logic egc, input logic egd);
    @(negedge clk);
    drive(cr, ca, cop, dr, dl, da, dop);
    push_exp(tag, egc, egd);
    #2;
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    reset_n   = 1'b0;
    exp_owner = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int   beat;
  int   cyc;
  logic egc;

  initial begin
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);

    // Reset held with both masters requesting: everything stays quiet.
    step("rst_hold", 1'b1, 32'h0000_0010, CPU_SW, 1'b1, 1'b1, 32'h0000_2000, DMA_WR, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    #1 reset_n = 1'b1;

    // CPU store with DMA idle.
    step("cpu_sw", 1'b1, 32'h0000_0010, CPU_SW, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Ties from reset alternate CPU, DMA, CPU, DMA.
    do_reset();
    for (int i = 0; i < 4; i++)
      step($sformatf("tie%0d", i), 1'b1, 32'h0000_0100 + 32'(i * 4), CPU_LW,
           1'b1, 1'b0, 32'h0000_3000 + 32'(i * 4), DMA_RD, (i % 2) == 0, (i % 2) == 1);

    // Locked 3-beat DMA burst with the CPU waiting throughout.
    step("lk_pre",   1'b1, 32'h0000_0200, CPU_LW, 1'b0, 1'b0, 32'h0,         4'h0,   1'b1, 1'b0);
    step("lk_b1",    1'b1, 32'h0000_0204, CPU_SW, 1'b1, 1'b1, 32'h0000_4000, DMA_WR, 1'b0, 1'b1);
    step("lk_b2",    1'b1, 32'h0000_0204, CPU_SW, 1'b1, 1'b1, 32'h0000_4004, DMA_WR, 1'b0, 1'b1);
    step("lk_b3",    1'b1, 32'h0000_0204, CPU_SW, 1'b1, 1'b0, 32'h0000_4008, DMA_WR, 1'b0, 1'b1);
    step("lk_cpu",   1'b1, 32'h0000_0204, CPU_SW, 1'b0, 1'b0, 32'h0,         4'h0,   1'b1, 1'b0);

    // DMA keeps its lock across an idle slot that the CPU takes.
    step("gap_d1",   1'b0, 32'h0,         4'h0,   1'b1, 1'b1, 32'h0000_5000, DMA_RD, 1'b0, 1'b1);
    step("gap_cpu",  1'b1, 32'h0000_0300, CPU_LW, 1'b0, 1'b1, 32'h0000_5004, DMA_RD, 1'b1, 1'b0);
    step("gap_d2",   1'b1, 32'h0000_0304, CPU_LW, 1'b1, 1'b1, 32'h0000_5004, DMA_RD, 1'b0, 1'b1);
    step("gap_d3",   1'b1, 32'h0000_0304, CPU_LW, 1'b1, 1'b0, 32'h0000_5008, DMA_RD, 1'b0, 1'b1);
    step("gap_cpu2", 1'b1, 32'h0000_0304, CPU_LW, 1'b0, 1'b0, 32'h0,         4'h0,   1'b1, 1'b0);

    // 12-beat locked burst with the CPU waiting.
    beat = 0;
    cyc  = 0;
    while (beat < 12 && cyc < 40) begin
`ifdef DBUS_STARVE_GUARD_EN
      egc = (cyc == 8);
`else
      egc = 1'b0;
`endif
      step($sformatf("long_c%0d", cyc), 1'b1, 32'h0000_0400 + 32'(cyc * 4), CPU_SW,
           1'b1, (beat < 11), 32'h0000_6000 + 32'(beat * 4), DMA_WR, egc, ~egc);
      if (!egc) beat++;
      cyc++;
    end
`ifdef DBUS_STARVE_GUARD_EN
    chk("long_cycles", 32'(cyc), 32'd13);
`else
    chk("long_cycles", 32'(cyc), 32'd12);
`endif
    step("long_cpu", 1'b1, 32'h0000_0480, CPU_SW, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a locked burst.
    step("ar_b1", 1'b0, 32'h0,         4'h0,   1'b1, 1'b1, 32'h0000_7000, DMA_WR, 1'b0, 1'b1);
    step("ar_b2", 1'b1, 32'h0000_0500, CPU_LW, 1'b1, 1'b1, 32'h0000_7004, DMA_WR, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 32'h0000_0500, CPU_LW, 1'b1, 1'b1, 32'h0000_7008, DMA_WR);
    #3;
    reset_n   = 1'b0;
    exp_owner = 1'b0;
    push_exp("ar_low", 1'b0, 1'b0);
    #1;
    check_out();
    #2;
    reset_n = 1'b1;
    step("ar_tie1", 1'b1, 32'h0000_0500, CPU_LW, 1'b1, 1'b1, 32'h0000_7008, DMA_WR, 1'b1, 1'b0);
    step("ar_tie2", 1'b1, 32'h0000_0504, CPU_LW, 1'b1, 1'b0, 32'h0000_7008, DMA_WR, 1'b0, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
